// File: rtl/match_frame_sched_pkg.sv
// Shared types and constants for the matcher frame scheduler: keypoint payload, FSM encoding,
// counter widths and a saturating increment helper.
package match_frame_sched_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned DESC_W  = 256;
    localparam int unsigned KP_W    = 2 * COORD_W + SCORE_W + DESC_W;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned ST_W    = 2;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SCORE_W-1:0] score;
        logic [DESC_W-1:0]  desc;
    } kp_t;

    localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
    localparam logic [ST_W-1:0] ST_ISSUE    = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT_RES = 2'd2;
    localparam logic [ST_W-1:0] ST_SWAP     = 2'd3;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/match_frame_sched_kp_fifo.sv
// Synchronous keypoint FIFO with registered full/empty flags; a push while full is refused
// even when a pop happens on the same cycle. Reset clears contents as well as pointers.
module match_frame_sched_kp_fifo
    import match_frame_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  kp_t  i_data,
    input  logic i_pop,
    output kp_t  o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [KP_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full_q, empty_q;
    logic            push_ok, pop_ok;

    assign push_ok = i_push && !full_q;
    assign pop_ok  = i_pop && !empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= i_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    assign o_head  = kp_t'(mem_q[rd_ptr_q]);
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule

// File: rtl/match_frame_sched.sv
// Frame sequencer feeding the descriptor matcher: queues keypoints, issues them one at a time,
// forwards match results and runs the end-of-frame swap. Optional watchdog: MATCH_SCHED_TIMEOUT_EN.
module match_frame_sched
    import match_frame_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MAX_KP      = 500,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_kp_valid,
    output logic               o_kp_ready,
    input  logic [COORD_W-1:0] i_kp_x,
    input  logic [COORD_W-1:0] i_kp_y,
    input  logic [SCORE_W-1:0] i_kp_score,
    input  logic [DESC_W-1:0]  i_kp_desc,
    input  logic               i_frame_end,
    output logic               o_m_flag,
    output logic [COORD_W-1:0] o_m_x,
    output logic [COORD_W-1:0] o_m_y,
    output logic [SCORE_W-1:0] o_m_score,
    output logic [DESC_W-1:0]  o_m_desc,
    input  logic               i_m_ack,
    input  logic               i_m_done,
    input  logic [COORD_W-1:0] i_m_src_x,
    input  logic [COORD_W-1:0] i_m_src_y,
    input  logic [COORD_W-1:0] i_m_dst_x,
    input  logic [COORD_W-1:0] i_m_dst_y,
    output logic               o_m_next,
    input  logic               i_m_end,
    output logic               o_match_valid,
    output logic [COORD_W-1:0] o_src_x,
    output logic [COORD_W-1:0] o_src_y,
    output logic [COORD_W-1:0] o_dst_x,
    output logic [COORD_W-1:0] o_dst_y,
    output logic [CNT_W-1:0]   o_match_cnt,
    output logic [CNT_W-1:0]   o_drop_cnt,
    output logic [FRAME_W-1:0] o_frame_cnt,
    output logic               o_busy,
    output logic               o_err_timeout
);

    localparam int unsigned ISS_W = $clog2(MAX_KP + 1);

    logic [ST_W-1:0]    state_q, state_d;
    logic [ISS_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               pending_q, pending_d;
    logic               match_valid_q, match_valid_d;
    logic [COORD_W-1:0] src_x_q, src_x_d, src_y_q, src_y_d;
    logic [COORD_W-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
    logic               err_q, err_d;
    logic               pop_c, push_c, tmo_hit_c;
    logic               fifo_full, fifo_empty;
    kp_t                kp_in, head;

    assign kp_in      = '{x: i_kp_x, y: i_kp_y, score: i_kp_score, desc: i_kp_desc};
    assign o_kp_ready = !fifo_full && !pending_q;
    assign push_c     = i_kp_valid && o_kp_ready;

    match_frame_sched_kp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_c),
        .i_data  (kp_in),
        .i_pop   (pop_c),
        .o_head  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Next-state, counters and result capture
    always_comb begin
        state_d       = state_q;
        issued_d      = issued_q;
        match_cnt_d   = match_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        pending_d     = pending_q | i_frame_end;
        match_valid_d = 1'b0;
        src_x_d       = src_x_q;
        src_y_d       = src_y_q;
        dst_x_d       = dst_x_q;
        dst_y_d       = dst_y_q;
        err_d         = err_q;
        pop_c         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (issued_q < ISS_W'(MAX_KP)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        pop_c      = 1'b1;
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end
                end else if (pending_q) begin
                    state_d = ST_SWAP;
                end
            end
            ST_ISSUE: begin
                if (i_m_ack) begin
                    pop_c    = 1'b1;
                    issued_d = issued_q + ISS_W'(1);
                    state_d  = ST_WAIT_RES;
                end else if (tmo_hit_c) begin
                    pop_c   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RES: begin
                if (i_m_done) begin
                    src_x_d       = i_m_src_x;
                    src_y_d       = i_m_src_y;
                    dst_x_d       = i_m_dst_x;
                    dst_y_d       = i_m_dst_y;
                    match_valid_d = 1'b1;
                    match_cnt_d   = sat_inc(match_cnt_q);
                    state_d       = ST_IDLE;
                end else if (tmo_hit_c) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_SWAP: begin
                if (i_m_end || tmo_hit_c) begin
                    pending_d   = 1'b0;
                    issued_d    = '0;
                    match_cnt_d = '0;
                    drop_cnt_d  = '0;
                    frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                    err_d       = err_q | (tmo_hit_c && !i_m_end);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MATCH_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Cycles spent in the current waiting state; restarts on every state change
    assign tmo_hit_c = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q != ST_IDLE) && (state_d == state_q)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_tmo;
    assign tmo_hit_c  = 1'b0;
    assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            issued_q      <= '0;
            match_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            pending_q     <= 1'b0;
            match_valid_q <= 1'b0;
            src_x_q       <= '0;
            src_y_q       <= '0;
            dst_x_q       <= '0;
            dst_y_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            issued_q      <= issued_d;
            match_cnt_q   <= match_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            pending_q     <= pending_d;
            match_valid_q <= match_valid_d;
            src_x_q       <= src_x_d;
            src_y_q       <= src_y_d;
            dst_x_q       <= dst_x_d;
            dst_y_q       <= dst_y_d;
            err_q         <= err_d;
        end
    end

    // Matcher drive comes straight from the FIFO head while offering
    assign o_m_flag      = (state_q == ST_ISSUE);
    assign o_m_next      = (state_q == ST_SWAP);
    assign o_m_x         = head.x;
    assign o_m_y         = head.y;
    assign o_m_score     = head.score;
    assign o_m_desc      = head.desc;
    assign o_match_valid = match_valid_q;
    assign o_src_x       = src_x_q;
    assign o_src_y       = src_y_q;
    assign o_dst_x       = dst_x_q;
    assign o_dst_y       = dst_y_q;
    assign o_match_cnt   = match_cnt_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign o_err_timeout = err_q;

endmodule

// File: tb/tb_match_frame_sched.sv
// Directed bench for match_frame_sched: main instance (MAX_KP=500) plus a MAX_KP=2 instance
// for the drop path. Watchdog scenario is selected with MATCH_SCHED_TIMEOUT_EN.
module tb_match_frame_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         kp_valid, frame_end, m_ack, m_done, m_end;
    logic [9:0]   kp_x, kp_y, m_src_x, m_src_y, m_dst_x, m_dst_y;
    logic [7:0]   kp_score;
    logic [255:0] kp_desc;
    logic         kp_ready, m_flag, m_next, match_valid, busy, err_timeout;
    logic [9:0]   m_x, m_y, src_x, src_y, dst_x, dst_y, match_cnt, drop_cnt;
    logic [7:0]   m_score;
    logic [255:0] m_desc;
    logic [15:0]  frame_cnt;

    logic         s_kp_valid, s_frame_end, s_m_ack, s_m_done, s_m_end;
    logic         s_kp_ready, s_m_flag, s_m_next, s_match_valid, s_busy, s_err_timeout;
    logic [9:0]   s_m_x, s_m_y, s_src_x, s_src_y, s_dst_x, s_dst_y, s_match_cnt, s_drop_cnt;
    logic [7:0]   s_m_score;
    logic [255:0] s_m_desc;
    logic [15:0]  s_frame_cnt;

    int checks   = 0;
    int failures = 0;
    int push_idx;

    match_frame_sched #(.FIFO_DEPTH(4), .MAX_KP(500), .TIMEOUT_CYC(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_kp_valid(kp_valid), .o_kp_ready(kp_ready),
        .i_kp_x(kp_x), .i_kp_y(kp_y), .i_kp_score(kp_score), .i_kp_desc(kp_desc),
        .i_frame_end(frame_end), .o_m_flag(m_flag), .o_m_x(m_x), .o_m_y(m_y),
        .o_m_score(m_score), .o_m_desc(m_desc), .i_m_ack(m_ack), .i_m_done(m_done),
        .i_m_src_x(m_src_x), .i_m_src_y(m_src_y), .i_m_dst_x(m_dst_x), .i_m_dst_y(m_dst_y),
        .o_m_next(m_next), .i_m_end(m_end), .o_match_valid(match_valid),
        .o_src_x(src_x), .o_src_y(src_y), .o_dst_x(dst_x), .o_dst_y(dst_y),
        .o_match_cnt(match_cnt), .o_drop_cnt(drop_cnt), .o_frame_cnt(frame_cnt),
        .o_busy(busy), .o_err_timeout(err_timeout)
    );

    match_frame_sched #(.FIFO_DEPTH(4), .MAX_KP(2), .TIMEOUT_CYC(16)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_kp_valid(s_kp_valid), .o_kp_ready(s_kp_ready),
        .i_kp_x(kp_x), .i_kp_y(kp_y), .i_kp_score(kp_score), .i_kp_desc(kp_desc),
        .i_frame_end(s_frame_end), .o_m_flag(s_m_flag), .o_m_x(s_m_x), .o_m_y(s_m_y),
        .o_m_score(s_m_score), .o_m_desc(s_m_desc), .i_m_ack(s_m_ack), .i_m_done(s_m_done),
        .i_m_src_x(m_src_x), .i_m_src_y(m_src_y), .i_m_dst_x(m_dst_x), .i_m_dst_y(m_dst_y),
        .o_m_next(s_m_next), .i_m_end(s_m_end), .o_match_valid(s_match_valid),
        .o_src_x(s_src_x), .o_src_y(s_src_y), .o_dst_x(s_dst_x), .o_dst_y(s_dst_y),
        .o_match_cnt(s_match_cnt), .o_drop_cnt(s_drop_cnt), .o_frame_cnt(s_frame_cnt),
        .o_busy(s_busy), .o_err_timeout(s_err_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_kp(input logic [9:0] x, input logic [9:0] y, input logic [7:0] sc);
        kp_x     = x;
        kp_y     = y;
        kp_score = sc;
        kp_desc  = {16{x[7:0], y[7:0]}};
    endtask

    // Advance one cycle, feeding the next burst keypoint whenever the last one was taken
    task automatic step_push();
        logic hs;
        hs = kp_valid && kp_ready;
        step();
        if (hs) begin
            push_idx++;
            if (push_idx < 6) set_kp(10'(100 + push_idx), 10'(200 + push_idx), 8'(push_idx));
            else kp_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        kp_valid = 0; frame_end = 0; m_ack = 0; m_done = 0; m_end = 0;
        s_kp_valid = 0; s_frame_end = 0; s_m_ack = 0; s_m_done = 0; s_m_end = 0;
        m_src_x = 0; m_src_y = 0; m_dst_x = 0; m_dst_y = 0;
        set_kp(10'd0, 10'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_flag !== 1'b0 || m_next !== 1'b0 || match_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: flag=%b next=%b mv=%b busy=%b, required all 0", m_flag, m_next, match_valid, busy);
        end
        checks++;
        if (match_cnt !== 10'd0 || drop_cnt !== 10'd0 || frame_cnt !== 16'd0 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt: match=%0d drop=%0d frame=%0d err=%b, required 0", match_cnt, drop_cnt, frame_cnt, err_timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [255:0] exp_desc;
        exp_desc = {16{8'd5, 8'd7}};
        set_kp(10'd5, 10'd7, 8'd40);
        kp_valid = 1'b1;
        step();
        kp_valid = 1'b0;
        checks++;
        if (m_flag !== 1'b0) begin
            failures++;
            $display("FAIL single_lat_early: flag=%b, required 0", m_flag);
        end
        step();
        checks++;
        if (m_flag !== 1'b1 || m_x !== 10'd5 || m_y !== 10'd7 || m_score !== 8'd40 || m_desc !== exp_desc) begin
            failures++;
            $display("FAIL single_issue: flag=%b x=%0d y=%0d score=%0d, required 1 5 7 40 and desc", m_flag, m_x, m_y, m_score);
        end
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        checks++;
        if (m_flag !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_wait: flag=%b busy=%b, required 0 1", m_flag, busy);
        end
        m_done = 1'b1; m_src_x = 10'd1; m_src_y = 10'd2; m_dst_x = 10'd5; m_dst_y = 10'd7;
        step();
        m_done = 1'b0;
        checks++;
        if (match_valid !== 1'b1 || src_x !== 10'd1 || src_y !== 10'd2 || dst_x !== 10'd5 || dst_y !== 10'd7 || match_cnt !== 10'd1) begin
            failures++;
            $display("FAIL single_result: mv=%b src=(%0d,%0d) dst=(%0d,%0d) cnt=%0d, required 1 (1,2) (5,7) 1",
                     match_valid, src_x, src_y, dst_x, dst_y, match_cnt);
        end
        step();
        checks++;
        if (match_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse: mv=%b, required 0", match_valid);
        end
    endtask

    task automatic test_burst();
        int n;
        push_idx = 0;
        set_kp(10'd100, 10'd200, 8'd0);
        kp_valid = 1'b1;
        n = 0;
        while (push_idx < 4 && n < 10) begin
            step_push();
            n++;
        end
        checks++;
        if (kp_ready !== 1'b0) begin
            failures++;
            $display("FAIL burst_ready_full: ready=%b, required 0 with 4 queued", kp_ready);
        end
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (m_flag !== 1'b1 && n < 30) begin
                step_push();
                n++;
            end
            checks++;
            if (m_flag !== 1'b1 || m_x !== 10'(100 + i) || m_y !== 10'(200 + i)) begin
                failures++;
                $display("FAIL burst_order[%0d]: flag=%b x=%0d y=%0d, required 1 %0d %0d", i, m_flag, m_x, m_y, 100 + i, 200 + i);
            end
            step_push();
            step_push();
            m_ack = 1'b1;
            step_push();
            m_ack = 1'b0;
            m_done = 1'b1; m_src_x = 10'(i); m_src_y = 10'(i); m_dst_x = 10'(100 + i); m_dst_y = 10'(200 + i);
            step_push();
            m_done = 1'b0;
            checks++;
            if (match_valid !== 1'b1 || match_cnt !== 10'(2 + i) || dst_x !== 10'(100 + i)) begin
                failures++;
                $display("FAIL burst_result[%0d]: mv=%b cnt=%0d dst_x=%0d, required 1 %0d %0d", i, match_valid, match_cnt, dst_x, 2 + i, 100 + i);
            end
        end
        checks++;
        if (push_idx != 6) begin
            failures++;
            $display("FAIL burst_all_pushed: pushed=%0d, required 6", push_idx);
        end
    endtask

    task automatic test_frame_end();
        int n;
        kp_valid = 1'b1;
        set_kp(10'd300, 10'd1, 8'd1);
        step();
        set_kp(10'd302, 10'd1, 8'd1);
        step();
        set_kp(10'd304, 10'd1, 8'd1);
        frame_end = 1'b1;
        step();
        kp_valid = 1'b0;
        frame_end = 1'b0;
        checks++;
        if (kp_ready !== 1'b0) begin
            failures++;
            $display("FAIL fe_ready_pending: ready=%b, required 0", kp_ready);
        end
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (m_flag !== 1'b1 && n < 30) begin
                step();
                n++;
            end
            checks++;
            if (m_flag !== 1'b1 || m_next !== 1'b0 || m_x !== 10'(300 + 2 * i)) begin
                failures++;
                $display("FAIL fe_issue[%0d]: flag=%b next=%b x=%0d, required 1 0 %0d", i, m_flag, m_next, m_x, 300 + 2 * i);
            end
            m_ack = 1'b1;
            step();
            m_ack = 1'b0;
            m_done = 1'b1;
            step();
            m_done = 1'b0;
        end
        n = 0;
        while (m_next !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (m_next !== 1'b1 || m_flag !== 1'b0 || match_cnt !== 10'd10 || drop_cnt !== 10'd0) begin
            failures++;
            $display("FAIL fe_swap_req: next=%b flag=%b match=%0d drop=%0d, required 1 0 10 0", m_next, m_flag, match_cnt, drop_cnt);
        end
        m_end = 1'b1;
        step();
        m_end = 1'b0;
        checks++;
        if (frame_cnt !== 16'd1 || match_cnt !== 10'd0 || kp_ready !== 1'b1 || m_next !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fe_swap_done: frame=%0d match=%0d ready=%b next=%b busy=%b, required 1 0 1 0 0",
                     frame_cnt, match_cnt, kp_ready, m_next, busy);
        end
    endtask

    task automatic test_max_kp();
        int pidx, acked;
        logic ack_prev, hs, seen_next, both;
        logic [9:0] ax [2];
        pidx = 0; acked = 0; ack_prev = 0; seen_next = 0; both = 0;
        ax[0] = '0; ax[1] = '0;
        set_kp(10'd10, 10'd0, 8'd0);
        s_kp_valid = 1'b1;
        for (int cyc = 0; cyc < 150 && !seen_next; cyc++) begin
            if (s_m_flag && s_m_next) both = 1'b1;
            if (s_m_next) begin
                seen_next = 1'b1;
            end else begin
                s_m_done    = ack_prev;
                s_m_ack     = s_m_flag;
                s_frame_end = (pidx == 4) && s_kp_valid && s_kp_ready;
                if (s_m_flag) begin
                    if (acked < 2) ax[acked] = s_m_x;
                    acked++;
                end
                hs = s_kp_valid && s_kp_ready;
                ack_prev = s_m_ack;
                step();
                if (hs) begin
                    pidx++;
                    if (pidx < 5) set_kp(10'(10 + pidx), 10'd0, 8'd0);
                    else s_kp_valid = 1'b0;
                end
            end
        end
        s_m_ack = 1'b0; s_m_done = 1'b0; s_frame_end = 1'b0; s_kp_valid = 1'b0;
        checks++;
        if (seen_next !== 1'b1 || both !== 1'b0) begin
            failures++;
            $display("FAIL maxkp_swap_req: next_seen=%b flag_and_next=%b, required 1 0", seen_next, both);
        end
        checks++;
        if (acked != 2 || ax[0] !== 10'd10 || ax[1] !== 10'd11) begin
            failures++;
            $display("FAIL maxkp_issued: issued=%0d x0=%0d x1=%0d, required 2 10 11", acked, ax[0], ax[1]);
        end
        checks++;
        if (s_drop_cnt !== 10'd3 || s_match_cnt !== 10'd2) begin
            failures++;
            $display("FAIL maxkp_counts: drop=%0d match=%0d, required 3 2", s_drop_cnt, s_match_cnt);
        end
        s_m_end = 1'b1;
        step();
        s_m_end = 1'b0;
        checks++;
        if (s_frame_cnt !== 16'd1 || s_drop_cnt !== 10'd0 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL maxkp_swap_done: frame=%0d drop=%0d busy=%b, required 1 0 0", s_frame_cnt, s_drop_cnt, s_busy);
        end
    endtask

    task automatic test_timeout();
        set_kp(10'd400, 10'd401, 8'd2);
        kp_valid = 1'b1;
        step();
        kp_valid = 1'b0;
        step();
        checks++;
        if (m_flag !== 1'b1 || m_x !== 10'd400) begin
            failures++;
            $display("FAIL tmo_issue: flag=%b x=%0d, required 1 400", m_flag, m_x);
        end
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
`ifdef MATCH_SCHED_TIMEOUT_EN
        repeat (15) step();
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tmo_before: err=%b busy=%b, required 0 1", err_timeout, busy);
        end
        step();
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || match_valid !== 1'b0) begin
            failures++;
            $display("FAIL tmo_fire: err=%b busy=%b mv=%b, required 1 0 0", err_timeout, busy, match_valid);
        end
        set_kp(10'd410, 10'd411, 8'd3);
        kp_valid = 1'b1;
        step();
        kp_valid = 1'b0;
        step();
        checks++;
        if (m_flag !== 1'b1 || m_x !== 10'd410) begin
            failures++;
            $display("FAIL tmo_recover_issue: flag=%b x=%0d, required 1 410", m_flag, m_x);
        end
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        m_done = 1'b1; m_src_x = 10'd9; m_src_y = 10'd9; m_dst_x = 10'd410; m_dst_y = 10'd411;
        step();
        m_done = 1'b0;
        checks++;
        if (match_valid !== 1'b1 || src_x !== 10'd9 || err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL tmo_recover_result: mv=%b src_x=%0d err=%b, required 1 9 1", match_valid, src_x, err_timeout);
        end
`else
        repeat (20) step();
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1 || m_flag !== 1'b0) begin
            failures++;
            $display("FAIL notmo_wait: err=%b busy=%b flag=%b, required 0 1 0", err_timeout, busy, m_flag);
        end
        m_done = 1'b1; m_src_x = 10'd7; m_src_y = 10'd8; m_dst_x = 10'd400; m_dst_y = 10'd401;
        step();
        m_done = 1'b0;
        checks++;
        if (match_valid !== 1'b1 || src_x !== 10'd7 || src_y !== 10'd8 || match_cnt !== 10'd1) begin
            failures++;
            $display("FAIL notmo_result: mv=%b src=(%0d,%0d) cnt=%0d, required 1 (7,8) 1", match_valid, src_x, src_y, match_cnt);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        kp_valid = 1'b1;
        set_kp(10'd500, 10'd1, 8'd1);
        step();
        set_kp(10'd501, 10'd1, 8'd1);
        step();
        set_kp(10'd502, 10'd1, 8'd1);
        step();
        kp_valid = 1'b0;
        m_ack = 1'b1;
        step();
        m_ack = 1'b0;
        checks++;
        if (busy !== 1'b1 || m_flag !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre_wait: busy=%b flag=%b, required 1 0", busy, m_flag);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_flag !== 1'b0 || m_next !== 1'b0 || busy !== 1'b0 || match_valid !== 1'b0 ||
            match_cnt !== 10'd0 || frame_cnt !== 16'd0 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL rst_async_clear: flag=%b next=%b busy=%b mv=%b match=%0d frame=%0d err=%b, required all 0",
                     m_flag, m_next, busy, match_valid, match_cnt, frame_cnt, err_timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        set_kp(10'd600, 10'd601, 8'd6);
        kp_valid = 1'b1;
        step();
        kp_valid = 1'b0;
        checks++;
        if (m_flag !== 1'b0) begin
            failures++;
            $display("FAIL rst_post_early: flag=%b, required 0", m_flag);
        end
        step();
        checks++;
        if (m_flag !== 1'b1 || m_x !== 10'd600 || m_y !== 10'd601) begin
            failures++;
            $display("FAIL rst_post_issue: flag=%b x=%0d y=%0d, required 1 600 601", m_flag, m_x, m_y);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_frame_end();
        test_max_kp();
        test_timeout();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
